// File: rtl/fc_act_loader.sv
// fc_act_loader: serial-to-parallel activation loader for the fully-connected layer.
// Collects IN beats of WIDTH-bit activations over a valid/ready stream into a
// register array, presents the array to the layer as x[0:IN-1], and holds it
// frozen until the downstream capture stage acknowledges with x_ack.
// Short frames are dropped and a missing s_last on the final beat is flagged,
// both with a one-cycle frame_err pulse.
module fc_act_loader #(
    parameter  int WIDTH = 8,
    parameter  int IN    = 400,
    localparam int CW    = $clog2(IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    // Serial activation stream
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    // Parallel frame towards the layer
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ack,
    // Status
    output logic [CW-1:0]    fill_count,
    output logic             frame_err
);

    // Index width for the buffer; kept at least one bit so IN=1 still elaborates.
    localparam int AW = (IN > 1) ? $clog2(IN) : 1;

    // fill_count value when the final beat of a frame arrives, and once held.
    localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(IN);

    typedef enum logic {
        FILL = 1'b0,   // accepting beats into the buffer
        HOLD = 1'b1    // frame complete, buffer frozen until x_ack
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       fill_count_q, fill_count_d;
    logic                frame_err_q, frame_err_d;
    logic                wr_en;
    logic [AW-1:0]       wr_idx;
    logic                beat_acc;
    logic [WIDTH-1:0]    buf_q [0:IN-1];

    // Handshake decode comes straight from the state register, so neither
    // s_ready nor x_valid has a combinational path from any input.
    assign s_ready  = (state_q == FILL);
    assign x_valid  = (state_q == HOLD);
    assign beat_acc = s_valid & s_ready;

    // The write slot is the number of beats already taken in this frame.
    assign wr_idx   = fill_count_q[AW-1:0];

    // Next-state, fill counter and error decisions for each accepted beat or ack.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        fill_count_d = fill_count_q;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            FILL: begin
                if (beat_acc) begin
                    if (fill_count_q == LAST_IDX) begin
                        // Final slot: frame is delivered regardless of s_last,
                        // but an absent s_last is still reported.
                        wr_en        = 1'b1;
                        state_d      = HOLD;
                        fill_count_d = FULL_CNT;
                        frame_err_d  = ~s_last;
                    end else if (s_last) begin
                        // Frame ended early: drop it. Stale buffer entries are
                        // simply overwritten by the next frame.
                        fill_count_d = '0;
                        frame_err_d  = 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        fill_count_d = fill_count_q + CW'(1);
                    end
                end
            end

            HOLD: begin
                // Release the frame; the next beat can be taken one cycle later.
                if (x_ack) begin
                    state_d      = FILL;
                    fill_count_d = '0;
                end
            end

            default: begin
                state_d      = FILL;
                fill_count_d = '0;
            end
        endcase
    end

    // Control registers: state, fill counter and the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= FILL;
            fill_count_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_count_q <= fill_count_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Activation buffer: one write per accepted beat while filling, frozen in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this array is reset on purpose: the layer reads x combinationally
        // at all times, so it must show zeros rather than X after reset. Plain
        // storage that nothing observes before it is written would not need it.
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_en) begin
            buf_q[wr_idx] <= s_data;
        end
    end

    assign x          = buf_q;
    assign fill_count = fill_count_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// tb_fc_act_loader: self-checking bench for fc_act_loader.
// Two instances run side by side on one clock and reset: a full-size layer
// (IN=400) and a small one (IN=4) for the framing-error scenarios. A per-frame
// reference model (beat count, hold flag, expected buffer image) is advanced
// each cycle from the driven stimulus and compared against every output.
module tb_fc_act_loader;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;

    // Per-instance stimulus: index 0 = IN=400, index 1 = IN=4.
    logic         sv  [2];
    logic         sl  [2];
    logic         ack [2];
    logic [W-1:0] sd  [2];

    logic         rdy0, rdy1, xv0, xv1, fe0, fe1;
    logic [W-1:0] big_x   [0:399];
    logic [W-1:0] small_x [0:3];
    logic [8:0]   fc0;
    logic [2:0]   fc1;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int           in_n [2] = '{400, 4};
    int           m_cnt  [2];
    bit           m_hold [2];
    bit           m_err  [2];
    logic [W-1:0] m_img  [2][400];

    always #5 clk = ~clk;

    fc_act_loader #(.WIDTH(W), .IN(400)) dut_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (sd[0]),
        .s_valid    (sv[0]),
        .s_last     (sl[0]),
        .s_ready    (rdy0),
        .x          (big_x),
        .x_valid    (xv0),
        .x_ack      (ack[0]),
        .fill_count (fc0),
        .frame_err  (fe0)
    );

    fc_act_loader #(.WIDTH(W), .IN(4)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (sd[1]),
        .s_valid    (sv[1]),
        .s_last     (sl[1]),
        .s_ready    (rdy1),
        .x          (small_x),
        .x_valid    (xv1),
        .x_ack      (ack[1]),
        .fill_count (fc1),
        .frame_err  (fe1)
    );

    function automatic logic dut_rdy(int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic dut_xv(int d);
        return (d == 0) ? xv0 : xv1;
    endfunction

    function automatic logic dut_fe(int d);
        return (d == 0) ? fe0 : fe1;
    endfunction

    function automatic int dut_fc(int d);
        return (d == 0) ? int'(fc0) : int'(fc1);
    endfunction

    function automatic logic [W-1:0] dut_x(int d, int i);
        return (d == 0) ? big_x[i] : small_x[i];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_hold[d] = 1'b0;
            m_err[d]  = 1'b0;
            for (int i = 0; i < 400; i++) m_img[d][i] = '0;
        end
    endtask

    // Apply the frame rules to the inputs currently driven on instance d.
    task automatic model_step(int d);
        m_err[d] = 1'b0;
        if (!m_hold[d]) begin
            if (sv[d] === 1'b1) begin
                if (m_cnt[d] == in_n[d] - 1) begin
                    m_img[d][m_cnt[d]] = sd[d];
                    m_hold[d] = 1'b1;
                    m_cnt[d]  = in_n[d];
                    m_err[d]  = (sl[d] !== 1'b1);
                end else if (sl[d] === 1'b1) begin
                    m_cnt[d] = 0;
                    m_err[d] = 1'b1;
                end else begin
                    m_img[d][m_cnt[d]] = sd[d];
                    m_cnt[d] = m_cnt[d] + 1;
                end
            end
        end else if (ack[d] === 1'b1) begin
            m_hold[d] = 1'b0;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic check_outputs(int d, string tag);
        int bad;
        logic [W-1:0] got;
        checks++;
        if (dut_rdy(d) !== (m_hold[d] ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL %s[%0d] s_ready got=%b exp=%b", tag, d, dut_rdy(d), !m_hold[d]);
        end
        checks++;
        if (dut_xv(d) !== m_hold[d]) begin
            failures++;
            $display("FAIL %s[%0d] x_valid got=%b exp=%b", tag, d, dut_xv(d), m_hold[d]);
        end
        checks++;
        if (dut_fc(d) != m_cnt[d]) begin
            failures++;
            $display("FAIL %s[%0d] fill_count got=%0d exp=%0d", tag, d, dut_fc(d), m_cnt[d]);
        end
        checks++;
        if (dut_fe(d) !== m_err[d]) begin
            failures++;
            $display("FAIL %s[%0d] frame_err got=%b exp=%b", tag, d, dut_fe(d), m_err[d]);
        end
        bad = -1;
        got = '0;
        for (int i = 0; i < in_n[d]; i++) begin
            if (bad < 0 && dut_x(d, i) !== m_img[d][i]) begin
                bad = i;
                got = dut_x(d, i);
            end
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s[%0d] x[%0d] got=%h exp=%h", tag, d, bad, got, m_img[d][bad]);
        end
    endtask

    // One clock: advance the model on the driven inputs, clock, then compare.
    task automatic cycle(string tag);
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d, tag);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            sv[d]  = 1'b0;
            sl[d]  = 1'b0;
            ack[d] = 1'b0;
            sd[d]  = '0;
        end
    endtask

    // Assert reset a few ns after an edge (asynchronous), check, then release.
    task automatic pulse_reset(string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int d = 0; d < 2; d++) check_outputs(d, tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d, tag);
    endtask

    task automatic test_reset();
        idle_inputs();
        sv[0] = 1'b1;
        sv[1] = 1'b1;
        sd[0] = 8'hEE;
        sd[1] = 8'hEE;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int d = 0; d < 2; d++) check_outputs(d, "reset_hold");
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d, "reset_clocked");
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release s_ready got=%b%b exp=11", rdy0, rdy1);
        end
        repeat (3) cycle("idle");
    endtask

    task automatic test_normal_frame();
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            sv[0] = 1'b1;
            sd[0] = 8'(k);
            sl[0] = (k == 399);
            cycle("normal");
        end
        idle_inputs();
        checks++;
        if (xv0 !== 1'b1 || rdy0 !== 1'b0) begin
            failures++;
            $display("FAIL normal_done x_valid=%b s_ready=%b exp 1/0", xv0, rdy0);
        end
        checks++;
        if (big_x[0] !== 8'h00 || big_x[255] !== 8'hFF || big_x[399] !== 8'h8F) begin
            failures++;
            $display("FAIL normal_values x0=%h x255=%h x399=%h exp 00/FF/8F",
                     big_x[0], big_x[255], big_x[399]);
        end
        // Held frame must ignore stream activity and stay frozen.
        for (int c = 0; c < 50; c++) begin
            sv[0] = 1'($urandom_range(0, 1));
            sd[0] = 8'($urandom);
            sl[0] = 1'($urandom_range(0, 1));
            cycle("normal_hold");
        end
        idle_inputs();
        checks++;
        if (fc0 !== 9'd400) begin
            failures++;
            $display("FAIL normal_count got=%0d exp=400", fc0);
        end
    endtask

    task automatic test_back_to_back();
        int accepted;
        bit err_seen;
        idle_inputs();
        ack[0] = 1'b1;
        sv[0]  = 1'b1;
        sd[0]  = 8'h33;
        cycle("ack");
        ack[0] = 1'b0;
        checks++;
        if (xv0 !== 1'b0 || rdy0 !== 1'b1 || fc0 !== 9'd0) begin
            failures++;
            $display("FAIL ack_release x_valid=%b s_ready=%b fill=%0d exp 0/1/0", xv0, rdy0, fc0);
        end
        accepted = 0;
        err_seen = 1'b0;
        while (!m_hold[0] && accepted < 1000) begin
            sv[0] = 1'b1;
            sd[0] = 8'h5A;
            sl[0] = (accepted == 399);
            cycle("b2b");
            accepted++;
            err_seen |= (fe0 === 1'b1);
        end
        idle_inputs();
        checks++;
        if (accepted != 400 || xv0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_len beats=%0d x_valid=%b exp 400/1", accepted, xv0);
        end
        checks++;
        if (err_seen) begin
            failures++;
            $display("FAIL b2b_err frame_err seen=1 exp=0");
        end
        checks++;
        if (big_x[0] !== 8'h5A || big_x[399] !== 8'h5A) begin
            failures++;
            $display("FAIL b2b_data x0=%h x399=%h exp 5A", big_x[0], big_x[399]);
        end
        ack[0] = 1'b1;
        cycle("b2b_ack");
        idle_inputs();
    endtask

    task automatic test_short_frame();
        logic [W-1:0] beats [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        idle_inputs();
        sv[1] = 1'b1; sd[1] = 8'h11; sl[1] = 1'b0;
        cycle("short");
        sd[1] = 8'h22; sl[1] = 1'b1;
        cycle("short");
        idle_inputs();
        checks++;
        if (fe1 !== 1'b1 || fc1 !== 3'd0) begin
            failures++;
            $display("FAIL short_err frame_err=%b fill=%0d exp 1/0", fe1, fc1);
        end
        cycle("short_after");
        checks++;
        if (fe1 !== 1'b0) begin
            failures++;
            $display("FAIL short_pulse frame_err=%b exp=0", fe1);
        end
        for (int k = 0; k < 4; k++) begin
            sv[1] = 1'b1;
            sd[1] = beats[k];
            sl[1] = (k == 3);
            cycle("refill");
        end
        idle_inputs();
        checks++;
        if (xv1 !== 1'b1 || fe1 !== 1'b0 || small_x[0] !== 8'hA1 || small_x[1] !== 8'hA2 ||
            small_x[2] !== 8'hA3 || small_x[3] !== 8'hA4) begin
            failures++;
            $display("FAIL refill x_valid=%b err=%b x=%h %h %h %h exp 1/0 A1 A2 A3 A4",
                     xv1, fe1, small_x[0], small_x[1], small_x[2], small_x[3]);
        end
        ack[1] = 1'b1;
        cycle("refill_ack");
        idle_inputs();
    endtask

    task automatic test_missing_last();
        logic [W-1:0] beats [4];
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            beats[k] = 8'($urandom);
            sv[1] = 1'b1;
            sd[1] = beats[k];
            sl[1] = 1'b0;
            cycle("nolast");
        end
        idle_inputs();
        checks++;
        if (xv1 !== 1'b1 || fe1 !== 1'b1) begin
            failures++;
            $display("FAIL nolast_flags x_valid=%b frame_err=%b exp 1/1", xv1, fe1);
        end
        checks++;
        if (small_x[0] !== beats[0] || small_x[1] !== beats[1] ||
            small_x[2] !== beats[2] || small_x[3] !== beats[3]) begin
            failures++;
            $display("FAIL nolast_data x=%h %h %h %h exp %h %h %h %h",
                     small_x[0], small_x[1], small_x[2], small_x[3],
                     beats[0], beats[1], beats[2], beats[3]);
        end
        cycle("nolast_after");
        checks++;
        if (fe1 !== 1'b0) begin
            failures++;
            $display("FAIL nolast_pulse frame_err=%b exp=0", fe1);
        end
        ack[1] = 1'b1;
        cycle("nolast_ack");
        idle_inputs();
    endtask

    task automatic test_backpressure_reset();
        idle_inputs();
        // Random gaps, random acks (ignored while filling), occasional early s_last.
        for (int c = 0; c < 300; c++) begin
            sv[1]  = ($urandom_range(0, 2) != 0);
            sd[1]  = 8'($urandom);
            sl[1]  = (m_cnt[1] == 3) ? 1'($urandom_range(0, 7) != 0)
                                     : ($urandom_range(0, 9) == 0);
            ack[1] = 1'($urandom_range(0, 1));
            cycle("random");
        end
        idle_inputs();
        for (int c = 0; c < 4 && m_hold[1]; c++) begin
            ack[1] = 1'b1;
            cycle("drain");
        end
        idle_inputs();
        sv[1] = 1'b1; sd[1] = 8'h77;
        cycle("pre_reset");
        sd[1] = 8'h78;
        cycle("pre_reset");
        pulse_reset("mid_frame_reset");
        checks++;
        if (fe1 !== 1'b0 || fc1 !== 3'd0 || xv1 !== 1'b0 || small_x[0] !== 8'h00 ||
            small_x[1] !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset err=%b fill=%0d x_valid=%b x0=%h x1=%h exp 0/0/0/00/00",
                     fe1, fc1, xv1, small_x[0], small_x[1]);
        end
        for (int k = 0; k < 4; k++) begin
            sv[1] = 1'b1;
            sd[1] = 8'hB0 + 8'(k);
            sl[1] = (k == 3);
            cycle("post_reset");
        end
        idle_inputs();
        checks++;
        if (xv1 !== 1'b1 || small_x[0] !== 8'hB0 || small_x[3] !== 8'hB3) begin
            failures++;
            $display("FAIL post_reset x_valid=%b x0=%h x3=%h exp 1/B0/B3", xv1, small_x[0], small_x[3]);
        end
        ack[1] = 1'b1;
        cycle("post_reset_ack");
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_normal_frame();
        test_back_to_back();
        test_short_frame();
        test_missing_last();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
